// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// MEM/WB writeback path and a long-latency unit (LLU). Writeback always wins;
// LLU results wait in a DEPTH-entry FIFO and drain on idle writeback cycles.
// Optional feature macro: RF_WR_BYPASS_EN (LLU result written straight to the
// register file when writeback is idle and the FIFO is empty).
module rf_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int MAX_STARVE = 8,
    parameter int DATA_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_we,
    input  logic [4:0]                   wb_rd,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         llu_valid,
    output logic                         llu_ready,
    input  logic [4:0]                   llu_rd,
    input  logic [DATA_W-1:0]            llu_data,
    output logic                         rf_we,
    output logic [4:0]                   rf_rd,
    output logic [DATA_W-1:0]            rf_data,
    input  logic [4:0]                   rs_q,
    input  logic [4:0]                   rt_q,
    output logic                         pend_hit,
    output logic                         stall_req,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int CNT_W = $clog2(MAX_STARVE+1);

    // FIFO storage; entry validity is tracked separately so WAW can kill slots
    logic [4:0]        rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    logic empty, full, acc, wb_wr, head_vld, byp, enq, deq;

    assign empty     = (count_q == '0);
    assign full      = (count_q == OCC_W'(DEPTH));
    assign llu_ready = rst_n && !full;
    assign acc       = llu_valid && llu_ready;
    assign wb_wr     = wb_we && (wb_rd != 5'd0);
    assign head_vld  = !empty && vld_q[head_q];
`ifdef RF_WR_BYPASS_EN
    assign byp       = acc && (llu_rd != 5'd0) && !wb_we && empty;
`else
    assign byp       = 1'b0;
`endif
    assign enq       = acc && (llu_rd != 5'd0) && !byp;
    // An invalidated head leaves even while writeback owns the port
    assign deq       = rst_n && !empty && (!wb_wr || !vld_q[head_q]);

    assign stall_req = rst_n && (starve_q == CNT_W'(MAX_STARVE));
    assign occupancy = rst_n ? count_q : '0;

    // Write-port mux: writeback, then bypassed LLU result, then valid FIFO head
    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = 5'd0;
        rf_data = '0;
        if (rst_n) begin
            if (wb_wr) begin
                rf_we   = 1'b1;
                rf_rd   = wb_rd;
                rf_data = wb_data;
            end else if (byp) begin
                rf_we   = 1'b1;
                rf_rd   = llu_rd;
                rf_data = llu_data;
            end else if (head_vld) begin
                rf_we   = 1'b1;
                rf_rd   = rd_mem_q[head_q];
                rf_data = data_mem_q[head_q];
            end
        end
    end

    // Hazard detect: decode sources against buffered writes and this cycle's accept
    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (rd_mem_q[i] == rs_q) && (rs_q != 5'd0)) pend_hit = 1'b1;
            if (vld_q[i] && (rd_mem_q[i] == rt_q) && (rt_q != 5'd0)) pend_hit = 1'b1;
        end
        if (acc && !byp && (llu_rd == rs_q) && (rs_q != 5'd0)) pend_hit = 1'b1;
        if (acc && !byp && (llu_rd == rt_q) && (rt_q != 5'd0)) pend_hit = 1'b1;
        if (!rst_n) pend_hit = 1'b0;
    end

    // Next-state for pointers, occupancy, entry validity and starvation counter
    always_comb begin
        vld_d  = vld_q;
        head_d = head_q + PTR_W'(deq);
        tail_d = tail_q + PTR_W'(enq);
        case ({enq, deq})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
        if (deq) vld_d[head_q] = 1'b0;
        // Writeback is younger than every buffered LLU op: older writes to its rd die
        if (wb_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_mem_q[i] == wb_rd) vld_d[i] = 1'b0;
            end
        end
        if (enq) vld_d[tail_q] = !(wb_wr && (wb_rd == llu_rd));
        if (empty || deq)
            starve_d = '0;
        else if (wb_we && head_vld && (starve_q != CNT_W'(MAX_STARVE)))
            starve_d = starve_q + CNT_W'(1);
        else
            starve_d = starve_q;
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            vld_q    <= vld_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // FIFO payload capture; validity bits make a reset of the payload unnecessary
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem_q[tail_q]   <= llu_rd;
            data_mem_q[tail_q] <= llu_data;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_rf_write_arbiter;

    localparam int DEPTH      = 4;
    localparam int MAX_STARVE = 8;
    localparam int DATA_W     = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wb_we = 1'b0;
    logic [4:0]        wb_rd = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              llu_valid = 1'b0;
    logic              llu_ready;
    logic [4:0]        llu_rd = '0;
    logic [DATA_W-1:0] llu_data = '0;
    logic              rf_we;
    logic [4:0]        rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic [4:0]        rs_q = '0;
    logic [4:0]        rt_q = '0;
    logic              pend_hit;
    logic              stall_req;
    logic [2:0]        occupancy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        bit                v;
    } ent_t;

    ent_t mq[$];
    int   m_starve;

    rf_write_arbiter #(.DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .llu_valid(llu_valid), .llu_ready(llu_ready), .llu_rd(llu_rd), .llu_data(llu_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .rs_q(rs_q), .rt_q(rt_q), .pend_hit(pend_hit), .stall_req(stall_req),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
        rs_q = '0; rt_q = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; llu_valid = 1'b1; llu_rd = 5'd5; rs_q = 5'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++; if (llu_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %0b want 0", llu_ready); end
            tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
            tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
            tests_run++; if (stall_req !== 1'b0 || pend_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_stall_pend: got %0b/%0b want 0/0", stall_req, pend_hit); end
            tick();
        end
        rst_n = 1'b1; llu_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (llu_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready: got %0b want 1", llu_ready); end
        tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL post_reset_occ: got %0d want 0", occupancy); end
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        llu_valid = 1'b1; llu_rd = 5'd5; llu_data = 32'hA5A5A5A5;
        @(negedge clk);
        tests_run++; if (llu_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_ready: got %0b want 1", llu_ready); end
`ifdef RF_WR_BYPASS_EN
        tests_run++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL drain_bypass: got we=%0b rd=%0d data=%h want 1/5/a5a5a5a5", rf_we, rf_rd, rf_data); end
`else
        tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL drain_same_cycle: got we=%0b want 0", rf_we); end
`endif
        tick();
        llu_valid = 1'b0;
        @(negedge clk);
`ifdef RF_WR_BYPASS_EN
        tests_run++; if (rf_we !== 1'b0 || occupancy !== 3'd0) begin tests_failed++; $display("FAIL drain_after_bypass: got we=%0b occ=%0d want 0/0", rf_we, occupancy); end
`else
        tests_run++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL drain_next: got we=%0b rd=%0d data=%h want 1/5/a5a5a5a5", rf_we, rf_rd, rf_data); end
        tests_run++; if (occupancy !== 3'd1) begin tests_failed++; $display("FAIL drain_occ1: got %0d want 1", occupancy); end
`endif
        tick();
        @(negedge clk);
        tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL drain_occ0: got %0d want 0", occupancy); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33333333;
        for (int i = 0; i < 4; i++) begin
            llu_valid = 1'b1; llu_rd = 5'(10 + i); llu_data = 32'(32'h1000 + i);
            @(negedge clk);
            tests_run++; if (llu_ready !== 1'b1 || rf_rd !== 5'd3 || rf_we !== 1'b1) begin tests_failed++; $display("FAIL full_push%0d: got ready=%0b rd=%0d we=%0b want 1/3/1", i, llu_ready, rf_rd, rf_we); end
            tick();
        end
        llu_rd = 5'd14; llu_data = 32'h1004; rs_q = 5'd14;
        @(negedge clk);
        tests_run++; if (occupancy !== 3'd4) begin tests_failed++; $display("FAIL full_occ: got %0d want 4", occupancy); end
        tests_run++; if (llu_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready: got %0b want 0", llu_ready); end
        tests_run++; if (pend_hit !== 1'b0) begin tests_failed++; $display("FAIL full_held_pend: got %0b want 0", pend_hit); end
        tick();
        rs_q = 5'd13;
        @(negedge clk);
        tests_run++; if (occupancy !== 3'd4 || pend_hit !== 1'b1) begin tests_failed++; $display("FAIL full_hold: got occ=%0d pend=%0b want 4/1", occupancy, pend_hit); end
        tick();
        wb_we = 1'b0; llu_valid = 1'b0; rs_q = 5'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++; if (rf_we !== 1'b1 || rf_rd !== 5'(10 + i) || rf_data !== 32'(32'h1000 + i)) begin tests_failed++; $display("FAIL full_drain%0d: got we=%0b rd=%0d data=%h", i, rf_we, rf_rd, rf_data); end
            tick();
        end
        @(negedge clk);
        tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL full_empty: got %0d want 0", occupancy); end
        tick();
    endtask

    task automatic test_starve();
        do_reset();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h3;
        llu_valid = 1'b1; llu_rd = 5'd6; llu_data = 32'h66;
        tick();
        llu_valid = 1'b0;
        for (int k = 1; k <= MAX_STARVE; k++) begin
            @(negedge clk);
            tests_run++; if (stall_req !== 1'b0) begin tests_failed++; $display("FAIL starve_early%0d: got %0b want 0", k, stall_req); end
            tick();
        end
        @(negedge clk);
        tests_run++; if (stall_req !== 1'b1 || occupancy !== 3'd1) begin tests_failed++; $display("FAIL starve_assert: got stall=%0b occ=%0d want 1/1", stall_req, occupancy); end
        tick();
        @(negedge clk);
        tests_run++; if (stall_req !== 1'b1) begin tests_failed++; $display("FAIL starve_hold: got %0b want 1", stall_req); end
        tick();
        wb_we = 1'b0;
        @(negedge clk);
        tests_run++; if (rf_we !== 1'b1 || rf_rd !== 5'd6 || stall_req !== 1'b1) begin tests_failed++; $display("FAIL starve_drain: got we=%0b rd=%0d stall=%0b want 1/6/1", rf_we, rf_rd, stall_req); end
        tick();
        @(negedge clk);
        tests_run++; if (stall_req !== 1'b0 || occupancy !== 3'd0) begin tests_failed++; $display("FAIL starve_clear: got stall=%0b occ=%0d want 0/0", stall_req, occupancy); end
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h3;
        llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h77;
        tick();
        llu_valid = 1'b0; rs_q = 5'd7;
        @(negedge clk);
        tests_run++; if (pend_hit !== 1'b1) begin tests_failed++; $display("FAIL waw_pend_before: got %0b want 1", pend_hit); end
        tick();
        wb_rd = 5'd7; wb_data = 32'h7070;
        @(negedge clk);
        tests_run++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'h7070) begin tests_failed++; $display("FAIL waw_wb_write: got we=%0b rd=%0d data=%h", rf_we, rf_rd, rf_data); end
        tick();
        wb_we = 1'b0;
        @(negedge clk);
        tests_run++; if (rf_we !== 1'b0 || pend_hit !== 1'b0 || occupancy !== 3'd1) begin tests_failed++; $display("FAIL waw_skip: got we=%0b pend=%0b occ=%0d want 0/0/1", rf_we, pend_hit, occupancy); end
        tick();
        @(negedge clk);
        tests_run++; if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL waw_popped: got %0d want 0", occupancy); end
        tick();
    endtask

    task automatic test_rd0_bypass();
        do_reset();
        llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'hDEAD;
        @(negedge clk);
        tests_run++; if (rf_we !== 1'b0 || llu_ready !== 1'b1) begin tests_failed++; $display("FAIL rd0_same: got we=%0b ready=%0b want 0/1", rf_we, llu_ready); end
        tick();
        llu_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (occupancy !== 3'd0 || rf_we !== 1'b0) begin tests_failed++; $display("FAIL rd0_discard: got occ=%0d we=%0b want 0/0", occupancy, rf_we); end
        tick();
`ifdef RF_WR_BYPASS_EN
        llu_valid = 1'b1; llu_rd = 5'd9; llu_data = 32'h99; rs_q = 5'd9;
        @(negedge clk);
        tests_run++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'h99 || pend_hit !== 1'b0) begin tests_failed++; $display("FAIL bypass_write: got we=%0b rd=%0d data=%h pend=%0b", rf_we, rf_rd, rf_data, pend_hit); end
        tick();
        llu_valid = 1'b0; rs_q = 5'd0;
        @(negedge clk);
        tests_run++; if (occupancy !== 3'd0 || rf_we !== 1'b0) begin tests_failed++; $display("FAIL bypass_no_enq: got occ=%0d we=%0b want 0/0", occupancy, rf_we); end
        tick();
`endif
    endtask

    function automatic bit model_pending(input logic [4:0] r, input bit acc_enq, input logic [4:0] lrd);
        bit hit = 1'b0;
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].v && mq[i].rd == r) hit = 1'b1;
        if (acc_enq && lrd == r) hit = 1'b1;
        return hit;
    endfunction

    task automatic test_random();
        bit dense = 1'b0;
        do_reset();
        mq.delete();
        m_starve = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int sz;
            bit e_ready, acc, wbw, byp, pop, e_we, e_pend, e_stall, enq_ok;
            logic [4:0] e_rd;
            logic [DATA_W-1:0] e_data;
            int e_occ, nst;
            if (cyc % 64 == 0) dense = 1'($urandom_range(0, 1));
            rst_n     = ($urandom_range(0, 199) != 0);
            wb_we     = dense ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 4);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            llu_valid = 1'($urandom_range(0, 1));
            llu_rd    = 5'($urandom_range(0, 7));
            llu_data  = $urandom;
            rs_q      = 5'($urandom_range(0, 7));
            rt_q      = 5'($urandom_range(0, 7));
            @(negedge clk);
            sz      = mq.size();
            e_ready = rst_n && (sz < DEPTH);
            acc     = llu_valid && e_ready;
            wbw     = rst_n && wb_we && (wb_rd != 5'd0);
            byp     = 1'b0;
`ifdef RF_WR_BYPASS_EN
            byp     = acc && (llu_rd != 5'd0) && !wb_we && (sz == 0);
`endif
            enq_ok  = acc && !byp;
            e_we = 1'b0; e_rd = '0; e_data = '0;
            if (wbw) begin e_we = 1'b1; e_rd = wb_rd; e_data = wb_data; end
            else if (byp) begin e_we = 1'b1; e_rd = llu_rd; e_data = llu_data; end
            else if (rst_n && sz > 0 && mq[0].v) begin e_we = 1'b1; e_rd = mq[0].rd; e_data = mq[0].data; end
            pop     = rst_n && (sz > 0) && (!wbw || !mq[0].v);
            e_pend  = rst_n && (model_pending(rs_q, enq_ok, llu_rd) || model_pending(rt_q, enq_ok, llu_rd));
            e_stall = rst_n && (m_starve == MAX_STARVE);
            e_occ   = rst_n ? sz : 0;
            tests_run++; if (llu_ready !== e_ready) begin tests_failed++; $display("FAIL rnd_ready c%0d: got %0b want %0b", cyc, llu_ready, e_ready); end
            tests_run++; if (rf_we !== e_we || rf_rd !== e_rd || rf_data !== e_data) begin tests_failed++; $display("FAIL rnd_port c%0d: got %0b/%0d/%h want %0b/%0d/%h", cyc, rf_we, rf_rd, rf_data, e_we, e_rd, e_data); end
            tests_run++; if (pend_hit !== e_pend) begin tests_failed++; $display("FAIL rnd_pend c%0d: got %0b want %0b", cyc, pend_hit, e_pend); end
            tests_run++; if (stall_req !== e_stall) begin tests_failed++; $display("FAIL rnd_stall c%0d: got %0b want %0b", cyc, stall_req, e_stall); end
            tests_run++; if (occupancy !== 3'(e_occ)) begin tests_failed++; $display("FAIL rnd_occ c%0d: got %0d want %0d", cyc, occupancy, e_occ); end
            if (!rst_n) begin
                mq.delete();
                m_starve = 0;
            end else begin
                if (sz == 0 || pop) nst = 0;
                else if (wb_we && mq[0].v && m_starve < MAX_STARVE) nst = m_starve + 1;
                else nst = m_starve;
                if (pop) void'(mq.pop_front());
                if (wbw) foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].v = 1'b0;
                if (enq_ok && llu_rd != 5'd0)
                    mq.push_back('{rd: llu_rd, data: llu_data, v: !(wbw && wb_rd == llu_rd)});
                m_starve = nst;
            end
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_drain();
        test_full();
        test_starve();
        test_waw();
        test_rd0_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
